// File: rtl/draw_sprite.sv
// draw_sprite: overlays an SPR_W x SPR_H sprite, fetched from an external synchronous ROM, onto
// the VGA stream. The position, mirror and enable inputs are latched on the rising edge of vblnk,
// so a sprite never tears mid-frame. Pixels that equal KEY_RGB are transparent. Every output
// field, sprite or not, is delayed by exactly LAT = ROM_LAT + 2 cycles.
//
// Ports:
//   clk, rst          pixel clock; asynchronous active-high reset
//   x_value, y_value  requested sprite top-left corner (screen coordinates)
//   mirror            1 = draw the sprite flipped horizontally
//   enable            0 = sprite hidden (stream passes through)
//   rgb_pixel         ROM data for the pixel_addr issued ROM_LAT cycles earlier
//   vga_in_*          incoming stream: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
//   vga_out_*         same fields, LAT cycles later, with the sprite overlaid
//   pixel_addr        registered ROM address (0 when there is no hit)
module draw_sprite #(
  parameter int unsigned SPR_W   = 48,
  parameter int unsigned SPR_H   = 64,
  parameter int unsigned ROM_LAT = 2,
  parameter int unsigned ADDR_W  = 12,
  parameter logic [11:0] KEY_RGB = 12'hFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       x_value,
  input  logic [11:0]       y_value,
  input  logic              mirror,
  input  logic              enable,
  input  logic [11:0]       rgb_pixel,
  input  logic [10:0]       vga_in_hcount,
  input  logic [10:0]       vga_in_vcount,
  input  logic              vga_in_hsync,
  input  logic              vga_in_vsync,
  input  logic              vga_in_hblnk,
  input  logic              vga_in_vblnk,
  input  logic [11:0]       vga_in_rgb,
  output logic [10:0]       vga_out_hcount,
  output logic [10:0]       vga_out_vcount,
  output logic              vga_out_hsync,
  output logic              vga_out_vsync,
  output logic              vga_out_hblnk,
  output logic              vga_out_vblnk,
  output logic [11:0]       vga_out_rgb,
  output logic [ADDR_W-1:0] pixel_addr
);

  // Delay-line depth: the address stage plus ROM_LAT stages waiting for ROM data.
  localparam int DLY = int'(ROM_LAT) + 1;
  // Packed VGA bundle: {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}.
  localparam int FW  = 38;

  // Frame-latched shadow registers.
  logic [11:0] sx, sy;
  logic        smir, sen, armed, vblnk_prev;
  logic        vblnk_rise;

  assign vblnk_rise = vga_in_vblnk & ~vblnk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx         <= '0;
      sy         <= '0;
      smir       <= 1'b0;
      sen        <= 1'b0;
      armed      <= 1'b0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vga_in_vblnk;
      if (vblnk_rise) begin
        sx    <= x_value;
        sy    <= y_value;
        smir  <= mirror;
        sen   <= enable;
        armed <= 1'b1;
      end
    end
  end

  // Stage 0: hit test and address calculation. 13-bit compares so sx + SPR_W never wraps.
  logic [12:0]       h13, v13, sx13, sy13, x_end, y_end;
  logic [12:0]       col_off, row_off, col13;
  logic              in_x, in_y, hit;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    h13       = {2'b00, vga_in_hcount};
    v13       = {2'b00, vga_in_vcount};
    sx13      = {1'b0, sx};
    sy13      = {1'b0, sy};
    x_end     = sx13 + 13'(SPR_W);
    y_end     = sy13 + 13'(SPR_H);
    in_x      = (h13 >= sx13) && (h13 < x_end);
    in_y      = (v13 >= sy13) && (v13 < y_end);
    hit       = armed & sen & ~vga_in_hblnk & ~vga_in_vblnk & in_x & in_y;
    col_off   = h13 - sx13;
    row_off   = v13 - sy13;
    col13     = smir ? (13'(SPR_W - 1) - col_off) : col_off;
    // Only meaningful when hit; row/col then fit in ADDR_W bits for legal parameters.
    addr_next = ADDR_W'(row_off) * ADDR_W'(SPR_W) + ADDR_W'(col13);
  end

  // Stage 1 onward: address register and the delay line that waits for ROM data.
  logic [FW-1:0]  fields_in;
  logic [FW-1:0]  fields_dly [DLY];
  logic [DLY-1:0] hit_dly;

  assign fields_in = {vga_in_hcount, vga_in_vcount, vga_in_hsync, vga_in_vsync,
                      vga_in_hblnk, vga_in_vblnk, vga_in_rgb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_addr <= '0;
      hit_dly    <= '0;
      for (int i = 0; i < DLY; i++) begin
        fields_dly[i] <= '0;
      end
    end else begin
      pixel_addr    <= hit ? addr_next : '0;
      hit_dly[0]    <= hit;
      fields_dly[0] <= fields_in;
      for (int i = 1; i < DLY; i++) begin
        hit_dly[i]    <= hit_dly[i-1];
        fields_dly[i] <= fields_dly[i-1];
      end
    end
  end

  // Output register: ROM data arrives aligned with the last delay-line stage.
  logic [FW-1:0] tail;
  logic [11:0]   rgb_sel;

  always_comb begin
    tail    = fields_dly[DLY-1];
    rgb_sel = (hit_dly[DLY-1] && (rgb_pixel != KEY_RGB)) ? rgb_pixel : tail[11:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_out_hcount <= '0;
      vga_out_vcount <= '0;
      vga_out_hsync  <= 1'b0;
      vga_out_vsync  <= 1'b0;
      vga_out_hblnk  <= 1'b0;
      vga_out_vblnk  <= 1'b0;
      vga_out_rgb    <= '0;
    end else begin
      vga_out_hcount <= tail[37:27];
      vga_out_vcount <= tail[26:16];
      vga_out_hsync  <= tail[15];
      vga_out_vsync  <= tail[14];
      vga_out_hblnk  <= tail[13];
      vga_out_vblnk  <= tail[12];
      vga_out_rgb    <= rgb_sel;
    end
  end

endmodule

// File: tb/tb_draw_sprite.sv
module tb_draw_sprite;
  localparam int SPR_W   = 48;
  localparam int SPR_H   = 64;
  localparam int ROM_LAT = 2;
  localparam int ADDR_W  = 12;
  localparam int LAT     = ROM_LAT + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [11:0]       x_value, y_value;
  logic              mirror, enable;
  logic [11:0]       rgb_pixel;
  logic [10:0]       in_h, in_v;
  logic              in_hs, in_vs, in_hb, in_vb;
  logic [11:0]       in_rgb;
  logic [10:0]       out_h, out_v;
  logic              out_hs, out_vs, out_hb, out_vb;
  logic [11:0]       out_rgb;
  logic [ADDR_W-1:0] pixel_addr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } pix_t;

  pix_t exp_q[$];

  // Reference model state.
  int m_sx, m_sy;
  bit m_mir, m_en, m_armed, m_prev_vb;

  draw_sprite #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_LAT(ROM_LAT), .ADDR_W(ADDR_W), .KEY_RGB(12'hFFF)
  ) dut (
    .clk(clk), .rst(rst), .x_value(x_value), .y_value(y_value), .mirror(mirror),
    .enable(enable), .rgb_pixel(rgb_pixel),
    .vga_in_hcount(in_h), .vga_in_vcount(in_v), .vga_in_hsync(in_hs), .vga_in_vsync(in_vs),
    .vga_in_hblnk(in_hb), .vga_in_vblnk(in_vb), .vga_in_rgb(in_rgb),
    .vga_out_hcount(out_h), .vga_out_vcount(out_v), .vga_out_hsync(out_hs),
    .vga_out_vsync(out_vs), .vga_out_hblnk(out_hb), .vga_out_vblnk(out_vb),
    .vga_out_rgb(out_rgb), .pixel_addr(pixel_addr)
  );

  always #5 clk = ~clk;

  // Sprite ROM contents: address 5 holds the colour key, all others never do.
  function automatic logic [11:0] rom_f(input int a);
    if (a == 5) return 12'hFFF;
    return 12'(a + 256);
  endfunction

  // Synchronous ROM with two cycles of read latency.
  logic [ADDR_W-1:0] rom_a1;
  always @(posedge clk) begin
    rom_a1    <= pixel_addr;
    rgb_pixel <= rom_f(int'(rom_a1));
  end

  task automatic prefill();
    exp_q.delete();
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
    m_sx = 0; m_sy = 0; m_mir = 0; m_en = 0; m_armed = 0; m_prev_vb = 0;
  endtask

  // Drive one pixel, predict its output, clock it, then check address and the output due now.
  task automatic step(input int h, input int v, input bit hb, input bit vb,
                      input logic [11:0] rgb);
    pix_t e, got, want;
    bit   hit_m;
    int   col, addr_m;
    in_h = 11'(h); in_v = 11'(v); in_hb = hb; in_vb = vb; in_rgb = rgb;
    in_hs = (h % 7 == 0); in_vs = (v % 5 == 0);
    hit_m = m_armed && m_en && !hb && !vb && v >= m_sy && v < m_sy + SPR_H &&
            h >= m_sx && h < m_sx + SPR_W;
    col = h - m_sx;
    if (m_mir) col = SPR_W - 1 - col;
    addr_m = hit_m ? (v - m_sy) * SPR_W + col : 0;
    e = '{h: in_h, v: in_v, hs: in_hs, vs: in_vs, hb: hb, vb: vb, rgb: rgb};
    if (hit_m && rom_f(addr_m) != 12'hFFF) e.rgb = rom_f(addr_m);
    exp_q.push_back(e);
    if (vb && !m_prev_vb) begin
      m_sx = int'(x_value); m_sy = int'(y_value); m_mir = mirror; m_en = enable; m_armed = 1;
    end
    m_prev_vb = vb;
    @(posedge clk); #1;
    checks++;
    if (pixel_addr !== ADDR_W'(addr_m)) begin
      errors++;
      $display("FAIL addr h=%0d v=%0d got %0d want %0d", h, v, pixel_addr, addr_m);
    end
    got  = '{h: out_h, v: out_v, hs: out_hs, vs: out_vs, hb: out_hb, vb: out_vb, rgb: out_rgb};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL vga_out got h=%0d v=%0d rgb=%h sync=%b%b%b%b want h=%0d v=%0d rgb=%h sync=%b%b%b%b",
               got.h, got.v, got.rgb, got.hs, got.vs, got.hb, got.vb,
               want.h, want.v, want.rgb, want.hs, want.vs, want.hb, want.vb);
    end
  endtask

  task automatic check_addr(input string name, input int want);
    checks++;
    if (pixel_addr !== ADDR_W'(want)) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, pixel_addr, want);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < LAT; i++) step(0, 0, 1'b1, 1'b0, 12'h000);
  endtask

  // Produce a vblnk rising edge so the current x/y/mirror/enable are latched.
  task automatic new_frame();
    step(0, 600, 1'b1, 1'b0, 12'h111);
    step(0, 601, 1'b1, 1'b1, 12'h222);
    step(0, 0, 1'b1, 1'b0, 12'h333);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x_value = 12'd100; y_value = 12'd100; mirror = 1'b0; enable = 1'b1;
    in_h = '0; in_v = '0; in_hs = 0; in_vs = 0; in_hb = 0; in_vb = 0; in_rgb = '0;
    @(posedge clk); #1;
    checks++;
    if ({out_h, out_v, out_hs, out_vs, out_hb, out_vb, out_rgb, pixel_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state got out=%h addr=%0d want all zero",
               {out_h, out_v, out_hs, out_vs, out_hb, out_vb, out_rgb}, pixel_addr);
    end
    rst = 1'b0;
    prefill();
  endtask

  task automatic test_unarmed();
    for (int v = 100; v < 103; v++)
      for (int h = 100; h < 106; h++) begin
        step(h, v, 1'b0, 1'b0, 12'(h ^ (v << 4)));
        check_addr("unarmed_addr", 0);
      end
  endtask

  task automatic test_frame();
    x_value = 12'd100; y_value = 12'd50; mirror = 1'b0; enable = 1'b1;
    new_frame();
    step(100, 50, 0, 0, 12'h0A0); check_addr("addr_100_50", 0);
    step(147, 50, 0, 0, 12'h0A0); check_addr("addr_147_50", 47);
    step(100, 51, 0, 0, 12'h0A0); check_addr("addr_100_51", 48);
    step(147, 113, 0, 0, 12'h0A0); check_addr("addr_147_113", 3071);
    step(148, 50, 0, 0, 12'h0B0); check_addr("miss_148", 0);
    step(100, 114, 0, 0, 12'h0C0); check_addr("miss_v114", 0);
    step(99, 50, 0, 0, 12'h0D0);
    step(100, 49, 0, 0, 12'h0E0);
    step(120, 60, 1, 0, 12'h0F0); check_addr("hblnk_no_hit", 0);
    drain();
  endtask

  task automatic test_mirror();
    mirror = 1'b1;
    new_frame();
    step(100, 50, 0, 0, 12'h0A0); check_addr("mir_addr_100", 47);
    step(147, 50, 0, 0, 12'h0A0); check_addr("mir_addr_147", 0);
    step(110, 70, 0, 0, 12'h0A0);
    drain();
  endtask

  task automatic test_colour_key();
    mirror = 1'b0;
    new_frame();
    step(105, 50, 0, 0, 12'h0A0); check_addr("key_addr", 5);
    step(106, 50, 0, 0, 12'h0A0);
    step(107, 50, 0, 0, 12'h0A0);
    step(0, 0, 1, 0, 12'h000);
    checks++;
    if (out_rgb !== 12'h0A0 || out_h !== 11'd105) begin
      errors++;
      $display("FAIL colour_key got h=%0d rgb=%h want h=105 rgb=0a0", out_h, out_rgb);
    end
    step(0, 0, 1, 0, 12'h000);
    checks++;
    if (out_rgb !== 12'(6 + 256)) begin
      errors++;
      $display("FAIL key_neighbour got %h want %h", out_rgb, 12'(6 + 256));
    end
    drain();
  endtask

  task automatic test_midframe_move();
    x_value = 12'd100;
    new_frame();
    step(110, 60, 0, 0, 12'h123);
    x_value = 12'd300;
    step(100, 80, 0, 0, 12'h123); check_addr("midframe_old_x", 30 * 48);
    step(300, 80, 0, 0, 12'h123); check_addr("midframe_new_x_miss", 0);
    step(120, 90, 0, 0, 12'h123);
    new_frame();
    step(300, 50, 0, 0, 12'h123); check_addr("next_frame_new_x", 0);
    step(310, 50, 0, 0, 12'h123); check_addr("next_frame_col10", 10);
    step(100, 50, 0, 0, 12'h456); check_addr("next_frame_old_miss", 0);
    drain();
  endtask

  task automatic test_back_to_back();
    x_value = 12'd100; y_value = 12'd50; mirror = 1'b1;
    new_frame();
    for (int h = 96; h < 152; h++) step(h, 60, 0, 0, 12'(h));
    drain();
  endtask

  task automatic test_clip_and_reset();
    x_value = 12'd4090; y_value = 12'd0; mirror = 1'b0;
    new_frame();
    step(0, 0, 0, 0, 12'h321); check_addr("nowrap_0", 0);
    step(20, 10, 0, 0, 12'h321);
    x_value = 12'd1000; y_value = 12'd740;
    new_frame();
    step(1000, 740, 0, 0, 12'h0A0); check_addr("clip_origin", 0);
    step(1023, 767, 0, 0, 12'h0A0); check_addr("clip_corner", 27 * 48 + 23);
    step(0, 740, 0, 0, 12'h0A0);    check_addr("clip_nowrap", 0);
    step(999, 740, 0, 0, 12'h0A0);
    step(1010, 750, 0, 0, 12'h0A0);
    // Asynchronous reset in the middle of a cycle.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_h, out_v, out_hs, out_vs, out_hb, out_vb, out_rgb, pixel_addr} !== '0) begin
      errors++;
      $display("FAIL async_reset got out=%h addr=%0d want all zero",
               {out_h, out_v, out_hs, out_vs, out_hb, out_vb, out_rgb}, pixel_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    prefill();
    step(1010, 750, 0, 0, 12'h0A0); check_addr("after_reset_no_sprite", 0);
    step(1011, 750, 0, 0, 12'h0A0);
    drain();
    new_frame();
    step(1010, 750, 0, 0, 12'h0A0); check_addr("rearmed", 10 * 48 + 10);
    drain();
  endtask

  initial begin
    test_reset();
    test_unarmed();
    test_frame();
    test_mirror();
    test_colour_key();
    test_midframe_move();
    test_back_to_back();
    test_clip_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
